// File: rtl/bus_xfer_pkg.sv
// bus_xfer_pkg -- shared types and constants for the bus transfer controller.
//   op_e    : request opcode (MOVE, READ_LHS, READ_RHS, RSVD)
//   state_e : controller sequencing states (IDLE, DRIVE, STROBE, HOLD)
//   SETTLE_DEFAULT / LOAD_DEFAULT : default phase lengths in cycles
package bus_xfer_pkg;

  typedef enum logic [1:0] {
    MOVE     = 2'b00,
    READ_LHS = 2'b01,
    READ_RHS = 2'b10,
    RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRIVE  = 2'b01,
    STROBE = 2'b10,
    HOLD   = 2'b11
  } state_e;

  localparam int SETTLE_DEFAULT = 1;
  localparam int LOAD_DEFAULT   = 1;

endpackage

// File: rtl/bus_xfer_dec.sv
// bus_xfer_dec -- index-to-one-hot decoder, active-low output.
//   idx     in  IDX_W     register index to select
//   en      in  1         when low, no output bit is selected
//   dec_bar out NUM_REGS  bit idx is 0 when en=1, all other bits 1
module bus_xfer_dec
  import bus_xfer_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] dec_bar
);

  // Indices outside 0..NUM_REGS-1 simply select nothing.
  always_comb begin
    dec_bar = '1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (idx == IDX_W'(i))) dec_bar[i] = 1'b0;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl -- sequences register-to-bus transfers:
// drive source (SETTLE_CYCLES), strobe LOAD (LOAD_CYCLES), hold one cycle.
//   CLK, RST          clock, asynchronous active-high reset
//   REQ_valid/ready   request handshake; ready only while IDLE
//   REQ_op/src/dst    opcode, source index, destination index (MOVE)
//   ASSERT_MAIN_bar   per-register main-bus drive enable, active-low
//   ASSERT_LHS_bar    per-register LHS-bus drive enable, active-low
//   ASSERT_RHS_bar    per-register RHS-bus drive enable, active-low
//   LOAD              per-register load (register captures on falling edge)
//   BUSY / DONE / ERR transfer in progress / completion pulse / reserved-op pulse
// Macro BUS_XFER_ERR_EN: when defined a reserved op only pulses ERR and the
// controller stays IDLE; otherwise it runs a silent full-length transfer,
// pulses DONE, and ERR is tied low.
// If RST hits during STROBE, LOAD falls asynchronously while the source bus
// is also released, so the destination may capture an undefined value.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int NUM_REGS      = 4,
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter int LOAD_CYCLES   = LOAD_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        REQ_valid,
  output logic                        REQ_ready,
  input  logic [1:0]                  REQ_op,
  input  logic [$clog2(NUM_REGS)-1:0] REQ_src,
  input  logic [$clog2(NUM_REGS)-1:0] REQ_dst,
  output logic [NUM_REGS-1:0]         ASSERT_MAIN_bar,
  output logic [NUM_REGS-1:0]         ASSERT_LHS_bar,
  output logic [NUM_REGS-1:0]         ASSERT_RHS_bar,
  output logic [NUM_REGS-1:0]         LOAD,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        ERR
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_e              state;
  logic [3:0]          cnt;
  logic [NUM_REGS-1:0] load_q;

  op_e                 req_op;
  logic                req_rsvd;
  logic                main_en, lhs_en, rhs_en;
  logic                start_xfer;
  logic [NUM_REGS-1:0] main_dec_bar, lhs_dec_bar, rhs_dec_bar, load_dec_bar;

  assign req_op = op_e'(REQ_op);

  // Out-of-range indices are folded into the reserved op; dst only matters for MOVE.
  assign req_rsvd = (req_op == RSVD)
                 || (32'(REQ_src) >= NUM_REGS)
                 || ((req_op == MOVE) && (32'(REQ_dst) >= NUM_REGS));

  assign main_en = (req_op == MOVE)     && !req_rsvd;
  assign lhs_en  = (req_op == READ_LHS) && !req_rsvd;
  assign rhs_en  = (req_op == READ_RHS) && !req_rsvd;

  // Ready is forced low during reset but returns the moment reset releases.
  assign REQ_ready = (state == IDLE) && !RST;

`ifdef BUS_XFER_ERR_EN
  assign start_xfer = REQ_valid && !req_rsvd;
`else
  assign start_xfer = REQ_valid;
`endif

  bus_xfer_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_main (
    .idx(REQ_src), .en(main_en), .dec_bar(main_dec_bar));
  bus_xfer_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_lhs (
    .idx(REQ_src), .en(lhs_en), .dec_bar(lhs_dec_bar));
  bus_xfer_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_rhs (
    .idx(REQ_src), .en(rhs_en), .dec_bar(rhs_dec_bar));
  bus_xfer_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_dec_load (
    .idx(REQ_dst), .en(main_en), .dec_bar(load_dec_bar));

  // Sequencer: the decoded enables are captured at accept so every bus and
  // LOAD output is a flop; LOAD is staged in load_q until STROBE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      cnt             <= '0;
      load_q          <= '0;
      ASSERT_MAIN_bar <= '1;
      ASSERT_LHS_bar  <= '1;
      ASSERT_RHS_bar  <= '1;
      LOAD            <= '0;
      BUSY            <= 1'b0;
      DONE            <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (start_xfer) begin
            state           <= DRIVE;
            cnt             <= '0;
            BUSY            <= 1'b1;
            ASSERT_MAIN_bar <= main_dec_bar;
            ASSERT_LHS_bar  <= lhs_dec_bar;
            ASSERT_RHS_bar  <= rhs_dec_bar;
            load_q          <= ~load_dec_bar;
          end
        end
        DRIVE: begin
          if (cnt == 4'(SETTLE_CYCLES - 1)) begin
            state <= STROBE;
            cnt   <= '0;
            LOAD  <= load_q;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        STROBE: begin
          if (cnt == 4'(LOAD_CYCLES - 1)) begin
            state <= HOLD;
            cnt   <= '0;
            LOAD  <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          state           <= IDLE;
          BUSY            <= 1'b0;
          DONE            <= 1'b1;
          ASSERT_MAIN_bar <= '1;
          ASSERT_LHS_bar  <= '1;
          ASSERT_RHS_bar  <= '1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_XFER_ERR_EN
  logic err_q;

  // A reserved request is consumed in IDLE and only flagged, one cycle later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= (state == IDLE) && REQ_valid && req_rsvd;
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4: number of general purpose registers controlled (2..8).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1: cycles a source drives a bus before any strobe (1..15).
REQ-003 The block SHALL have parameter LOAD_CYCLES, default 1: cycles LOAD is held high (1..15).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: CLK and RST.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  asynchronous reset, active-high
- REQ_valid  in  1  a request is presented
- REQ_ready  out  1  the controller accepts a request this cycle
- REQ_op  in  2  00 MOVE, 01 READ_LHS, 10 READ_RHS, 11 reserved
- REQ_src  in  clog2(NUM_REGS)  source register index
- REQ_dst  in  clog2(NUM_REGS)  destination index (MOVE only)
- ASSERT_MAIN_bar  out  NUM_REGS  per-register main-bus drive enable, active-low
- ASSERT_LHS_bar  out  NUM_REGS  per-register LHS-bus drive enable, active-low
- ASSERT_RHS_bar  out  NUM_REGS  per-register RHS-bus drive enable, active-low
- LOAD  out  NUM_REGS  per-register load; the register captures on the falling edge
- BUSY  out  1  a transfer is in progress
- DONE  out  1  one-cycle pulse when a transfer completes
- ERR  out  1  one-cycle pulse for a reserved op (macro-dependent)

Function
REQ-006 The controller SHALL accept a request on a rising edge where REQ_valid=1 and REQ_ready=1, and SHALL register REQ_op, REQ_src and REQ_dst at that edge.
REQ-007 REQ_ready SHALL equal 1 exactly when the state is IDLE.
REQ-008 The state machine SHALL have four states: IDLE, DRIVE, STROBE and HOLD.
REQ-009 The state machine SHALL make these transitions:
- IDLE->DRIVE on accept
- DRIVE->STROBE after SETTLE_CYCLES cycles
- STROBE->HOLD after LOAD_CYCLES cycles
- HOLD->IDLE after 1 cycle
REQ-010 Bus driving SHALL depend on the op:
- MOVE: ASSERT_MAIN_bar[src]=0 throughout DRIVE, STROBE and HOLD
- READ_LHS: ASSERT_LHS_bar[src]=0 throughout DRIVE, STROBE and HOLD
- READ_RHS: ASSERT_RHS_bar[src]=0 throughout DRIVE, STROBE and HOLD
REQ-011 For MOVE, LOAD[dst]=1 only in STROBE, so that the falling edge of LOAD occurs while the source is still driving; READ ops SHALL never raise LOAD.
REQ-012 All enables and LOAD SHALL be registered outputs with no combinational path from request inputs.
REQ-013 At most one bit of each ASSERT_*_bar vector SHALL be 0 at any time, and at most one LOAD bit SHALL be 1.
REQ-014 DONE SHALL pulse for one cycle in the first IDLE cycle after HOLD; latency from accept to DONE SHALL be SETTLE_CYCLES+LOAD_CYCLES+2 cycles.
REQ-015 BUSY SHALL be 1 in DRIVE, STROBE and HOLD.
REQ-016 A new request SHALL be acceptable in the same cycle DONE is high (back-to-back transfers, no idle gap).
REQ-017 MOVE with src==dst SHALL be legal and SHALL execute normally.
REQ-018 A MOVE or READ with a src or dst index >= NUM_REGS SHALL be treated as the reserved op.
REQ-019 Requests presented while not in IDLE SHALL be ignored; REQ_valid SHALL NOT need to be held.

Reset
REQ-020 While RST=1 the block SHALL immediately force:
- all ASSERT_*_bar = all ones
- LOAD = 0
- BUSY = DONE = ERR = 0
- REQ_ready = 0
- state = IDLE
REQ-021 On RST deassertion, REQ_ready SHALL be 1 in the first cycle.
REQ-022 Reset asserted during STROBE SHALL drop LOAD asynchronously; the destination capturing an undefined value in that case SHALL be accepted and documented behaviour.

Configuration
REQ-023 With macro BUS_XFER_ERR_EN defined, a reserved op SHALL be accepted, SHALL pulse ERR the next cycle, SHALL drive no bus, SHALL raise no LOAD and SHALL NOT pulse DONE.
REQ-024 Without BUS_XFER_ERR_EN, a reserved op SHALL run the full DRIVE/STROBE/HOLD timing with no bus or LOAD activity, SHALL then pulse DONE, and ERR SHALL be tied to 0.

Structure
REQ-025 A shared package bus_xfer_pkg SHALL hold the op enum (MOVE, READ_LHS, READ_RHS, RSVD), the state enum, and the default SETTLE/LOAD constants.
REQ-026 A sub-module bus_xfer_dec SHALL decode an index plus enable into an active-low one-hot vector, instantiated once per bus and once (inverted) for LOAD.

Verification
REQ-027 With defaults, MOVE src=1 dst=2 accepted at cycle 0 SHALL produce ASSERT_MAIN_bar=4'b1101 in cycles 1-3, LOAD=4'b0100 in cycle 2 only, and DONE in cycle 4.
REQ-028 READ_RHS src=3 SHALL produce ASSERT_RHS_bar=4'b0111 for 3 cycles and LOAD=0 throughout.
REQ-029 Back-to-back MOVE requests with REQ_valid held high SHALL be accepted on cycles 0 and 4, with no overlap of enables.
REQ-030 With SETTLE_CYCLES=3 and LOAD_CYCLES=2, DONE SHALL occur 7 cycles after accept.
REQ-031 RST asserted during DRIVE SHALL return all outputs to reset values within the same cycle, with REQ_ready=1 after release.
REQ-032 Op 11 SHALL pulse ERR one cycle after accept when BUS_XFER_ERR_EN is defined, and SHALL pulse DONE at cycle 4 when it is not; in both cases no enable and no LOAD SHALL activate.
